// File: rtl/note_player.sv
`default_nettype none
// ============================================================================
// Module   : note_player
// Purpose  : Holds a note for a number of beats (BEAT_DIV clocks each), emits a
//            beat strobe and a single note_done so the song reader advances.
// Revision : 1.0 - initial release
// ============================================================================
module note_player #(
  parameter int BEAT_DIV  = 1000,
  parameter int CNT_WIDTH = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  input  logic       new_note,
  input  logic [5:0] note,
  input  logic [5:0] duration,
  output logic       note_done,
  output logic [5:0] active_note,
  output logic       note_active,
  output logic       beat
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAYING = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(BEAT_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [5:0]           rem_q;
  logic [5:0]           rem_d;
  logic [5:0]           active_note_q;
  logic                 note_active_q;
  logic                 beat_q;
  logic                 beat_tick;
  logic                 last_beat;

  assign beat_tick = (cnt_q == CNT_LAST);
  assign last_beat = beat_tick && (rem_q <= 6'd1);
  assign cnt_d     = beat_tick ? '0 : (cnt_q + CNT_ONE);
  // Saturate so the beat count can never wrap past zero.
  assign rem_d     = (beat_tick && (rem_q != 6'd0)) ? (rem_q - 6'd1) : rem_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rem_q         <= 6'd0;
      active_note_q <= 6'd0;
      note_active_q <= 1'b0;
      beat_q        <= 1'b0;
    end else if (play) begin
      beat_q <= 1'b0;
      if (new_note) begin
        // A load wins in every state, including preemption of a playing note.
        active_note_q <= note;
        rem_q         <= duration;
        cnt_q         <= '0;
        if (duration != 6'd0) begin
          state_q       <= S_PLAYING;
          note_active_q <= (note != 6'd0);
        end else begin
          state_q       <= S_DONE;
          note_active_q <= 1'b0;
        end
      end else begin
        unique case (state_q)
          S_IDLE: begin
            active_note_q <= 6'd0;
            note_active_q <= 1'b0;
          end
          S_PLAYING: begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            beat_q <= beat_tick;
            if (last_beat) begin
              state_q       <= S_DONE;
              note_active_q <= 1'b0;
            end
          end
          S_DONE: begin
            state_q       <= S_IDLE;
            active_note_q <= 6'd0;
            note_active_q <= 1'b0;
          end
          default: begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rem_q         <= 6'd0;
            active_note_q <= 6'd0;
            note_active_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Qualified by play so a paused DONE cannot emit more than one pulse.
  assign note_done   = (state_q == S_DONE) && play;
  assign active_note = active_note_q;
  assign note_active = note_active_q;
  assign beat        = beat_q;

endmodule
`default_nettype wire

// File: tb/tb_note_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_player
// Purpose  : Self-checking bench for note_player: directed table, corner
//            sequences and randomized traffic against an elapsed-time model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_player;

  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       play;
  logic       new_note;
  logic [5:0] note;
  logic [5:0] duration;
  logic       note_done;
  logic [5:0] active_note;
  logic       note_active;
  logic       beat;

  int n_chk  = 0;
  int n_fail = 0;

  note_player #(.BEAT_DIV(BD), .CNT_WIDTH(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .new_note   (new_note),
    .note       (note),
    .duration   (duration),
    .note_done  (note_done),
    .active_note(active_note),
    .note_active(note_active),
    .beat       (beat)
  );

  always #5 clk = ~clk;

  // Model: a note lasts dur*BD play-qualified edges after its load edge.
  bit m_playing, m_done, m_beat;
  int m_note, m_dur, m_elapsed;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_playing = 0; m_done = 0; m_beat = 0;
    m_note = 0; m_dur = 0; m_elapsed = 0;
  endtask

  task automatic model_step(input bit p, input bit nn, input int n, input int d);
    if (!p) return;
    if (nn) begin
      m_note = n; m_dur = d; m_elapsed = 0; m_beat = 0;
      m_playing = (d != 0);
      m_done    = (d == 0);
    end else if (m_playing) begin
      m_elapsed++;
      m_beat = (m_elapsed % BD) == 0;
      if (m_elapsed == m_dur * BD) begin
        m_playing = 0;
        m_done    = 1;
      end
    end else if (m_done) begin
      m_done = 0; m_note = 0; m_beat = 0;
    end else begin
      m_beat = 0;
    end
  endtask

  // One clock: drive, check combinational note_done, edge, check registers.
  task automatic cyc(input bit p, input bit nn, input int n, input int d);
    play = p; new_note = nn; note = 6'(n); duration = 6'(d);
    #1;
    chk("note_done", int'(note_done), int'(m_done && p));
    @(posedge clk);
    model_step(p, nn, n, d);
    #1;
    chk("active_note", int'(active_note), m_note);
    chk("note_active", int'(note_active), int'(m_playing && (m_note != 0)));
    chk("beat", int'(beat), int'(m_beat));
    new_note = 1'b0;
  endtask

  task automatic async_reset_check();
    reset = 1'b1;
    #2;
    chk("rst_active_note", int'(active_note), 0);
    chk("rst_note_active", int'(note_active), 0);
    chk("rst_beat", int'(beat), 0);
    chk("rst_note_done", int'(note_done), 0);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit       p;
    bit       nn;
    int       n;
    int       d;
    bit       exp_done;
    int       exp_active;
    bit       exp_na;
    bit       exp_beat;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // note 20 for 3 beats: beats after edges 4, 8, 12, done in cycle 13.
    tbl[0]  = '{1, 1, 20, 3, 0, 20, 1, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 20, 1, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 20, 1, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 20, 1, 0};
    tbl[4]  = '{1, 0, 0, 0, 0, 20, 1, 1};
    tbl[5]  = '{1, 0, 0, 0, 0, 20, 1, 0};
    tbl[6]  = '{1, 0, 0, 0, 0, 20, 1, 0};
    tbl[7]  = '{1, 0, 0, 0, 0, 20, 1, 0};
    tbl[8]  = '{1, 0, 0, 0, 0, 20, 1, 1};
    tbl[9]  = '{1, 0, 0, 0, 0, 20, 1, 0};
    tbl[10] = '{1, 0, 0, 0, 0, 20, 1, 0};
    tbl[11] = '{1, 0, 0, 0, 0, 20, 1, 0};
    tbl[12] = '{1, 0, 0, 0, 0, 20, 0, 1};
    tbl[13] = '{1, 0, 0, 0, 1, 0, 0, 0};
    tbl[14] = '{1, 0, 0, 0, 0, 0, 0, 0};

    reset = 1'b1; play = 1'b1; new_note = 1'b0; note = '0; duration = '0;
    model_reset();
    #12;
    chk("reset_active_note", int'(active_note), 0);
    chk("reset_note_active", int'(note_active), 0);
    chk("reset_beat", int'(beat), 0);
    chk("reset_note_done", int'(note_done), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      play = tbl[i].p; new_note = tbl[i].nn;
      note = 6'(tbl[i].n); duration = 6'(tbl[i].d);
      #1;
      chk($sformatf("tbl%0d_note_done", i), int'(note_done), int'(tbl[i].exp_done));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_active_note", i), int'(active_note), tbl[i].exp_active);
      chk($sformatf("tbl%0d_note_active", i), int'(note_active), int'(tbl[i].exp_na));
      chk($sformatf("tbl%0d_beat", i), int'(beat), int'(tbl[i].exp_beat));
      new_note = 1'b0;
    end

    // Resynchronize the model with a fresh reset before model-checked runs.
    async_reset_check();

    // Zero-length note: done right after the load, no beat, no gate.
    cyc(1, 1, 5, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);

    // Rest of 2 beats: gate stays low throughout.
    cyc(1, 1, 0, 2);
    for (int i = 0; i < 11; i++) cyc(1, 0, 0, 0);

    // Pause mid-note for 5 cycles.
    cyc(1, 1, 9, 2);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);

    // Pause while in DONE, plus a new_note ignored during the pause.
    cyc(1, 1, 11, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 33, 2);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);

    // Back-to-back: load lands in the note_done cycle.
    cyc(1, 1, 3, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    cyc(1, 1, 7, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);

    // Preemption mid-note, then async reset mid-note and a normal replay.
    cyc(1, 1, 12, 3);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
    cyc(1, 1, 13, 1);
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0);
    async_reset_check();
    cyc(1, 1, 14, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      bit p, nn;
      int n, d;
      p  = ($urandom % 8) != 0;
      nn = ($urandom % 10) == 0;
      n  = (($urandom % 4) == 0) ? 0 : int'($urandom % 64);
      d  = int'($urandom % 4);
      cyc(p, nn, n, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/note_player.md
Name: note_player

Overview:
- Consumer end of the song-reader note handshake.
- Accepts a `new_note` pulse carrying `note`/`duration` and holds that note as the active note for `duration` beats, dividing the system clock into beats internally.
- Returns a single-cycle `note_done` so the song reader advances exactly one note.
- Sits between the song reader and the frequency/sample generator. It drives the active note index, a gate, and a beat strobe downstream.

Parameters:
- BEAT_DIV, default 1000: clock cycles per duration beat; legal range >= 1.
- CNT_WIDTH, default 10: width of the beat divider counter; must satisfy 2^CNT_WIDTH >= BEAT_DIV.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- play  input  1  run enable; low freezes all counting and state.
- new_note  input  1  one-cycle strobe; note/duration valid in the same cycle.
- note  input  6  note index; 0 = rest.
- duration  input  6  length in beats; 0 = zero-length note.
- note_done  output  1  high for exactly one play-high cycle when the current note finishes.
- active_note  output  6  registered note index being played; 0 when idle.
- note_active  output  1  registered gate; high in PLAYING with active_note != 0.
- beat  output  1  one-cycle strobe on each beat boundary while PLAYING.

Behaviour:
- Reset values:
  - State IDLE.
  - Divider counter 0, remaining-beats register 0.
  - `active_note`=0, `note_active`=0, `note_done`=0, `beat`=0.
- All outputs are registered except `note_done`, which is (state==DONE) & `play`.
- Nothing changes on an edge where `play`=0; all inputs, including `new_note`, are ignored that cycle.
- Load, on an edge where `play`=1, `new_note`=1 and state is IDLE, PLAYING or DONE:
  - `active_note`<=`note`; remaining<=`duration`; counter<=0.
  - If `duration`!=0: state<=PLAYING. If `duration`==0: state<=DONE.
  - Load in PLAYING preempts the current note; no `note_done` is issued for the preempted note.
- PLAYING, `play`=1, no `new_note`:
  - If counter==BEAT_DIV-1: counter<=0, `beat`<=1, remaining<=remaining-1. Otherwise counter<=counter+1 and `beat`<=0.
  - When a beat takes remaining from 1 to 0: state<=DONE on that same edge.
- DONE:
  - `note_done` is high while `play`=1.
  - On the next `play`=1 edge, state<=IDLE and `active_note`<=0, unless `new_note` loads, which takes priority.
  - If `play`=0, DONE holds and `note_done` stays low until play returns. This guarantees exactly one qualified pulse.
- IDLE: `active_note`=0, `note_active`=0; waits for `new_note`.
- Latency, with `play` held high and load at edge E0:
  - `duration` D>0: `note_done` is high in the cycle after edge E0+D*BEAT_DIV.
  - D=0: `note_done` is high in the cycle right after E0.
- `beat` fires D times per uninterrupted note.
- `note_active` = (next state==PLAYING) & (next `active_note`!=0), registered. Rests count duration silently.
- Width rules:
  - remaining is 6 bits and never wraps below 0.
  - The counter compares against BEAT_DIV-1 at CNT_WIDTH bits. BEAT_DIV=1 gives a beat every PLAYING cycle.
- Reset mid-note: immediate return to reset values; no `note_done` is generated.

Test Plan:
- BEAT_DIV=4, `play`=1, `new_note` with `note`=6'd20 and `duration`=6'd3 → `note_active`=1 and `active_note`=20 after the load edge; `beat` pulses at cycles 4, 8, 12; `note_done` high exactly one cycle after edge 12; `active_note` returns to 0 the next cycle.
- `duration`=0, `note`=6'd5 → `note_done` high the cycle after load; no `beat`; `note_active` never asserts.
- Rest: `note`=0, `duration`=2 → `note_active` stays 0 throughout; `note_done` after 8 cycles.
- Pause: drop `play` for 5 cycles mid-note (`duration`=2) → counter and outputs frozen; `note_done` delayed by exactly 5 cycles. Separately, drop `play` while in DONE → `note_done` low until `play` returns, then high for one cycle.
- Back-to-back: assert `new_note` (`note`=7, `duration`=1) in the cycle `note_done` is high → direct DONE→PLAYING; single `note_done` per note; second `note_done` 4 cycles later.
- Assert reset asynchronously mid-PLAYING → outputs 0 without waiting for a clk edge; next `new_note` after release plays normally.
